sdram_wb_arbiter: RTL
=====================

# sdram_wb_arbiter

Two-master to one-slave Wishbone classic arbiter that shares the SDRAM controller's Wishbone port between the CPU (m0) and a secondary master such as a DMA or instruction fetch path (m1). It holds a grant for the owner's whole bus cycle and arbitrates round-robin when both masters request. It forces a fresh cycle on the slave whenever ownership changes. It sits in the wb_clk domain between the masters and the SDRAM controller's wishbone slave; the controller's internal CDC to sdram_clk is untouched.

## Interface
- AW, 32, address width
- DW, 32, data width; SEL width = DW/8
- TIMEOUT, 255, watchdog limit in wb_clk cycles (8-bit counter, 1..255)
- wb_clk  in  1  Wishbone clock
- wb_rst_n  in  1  reset, asynchronous assert, active-low
- m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i  in  AW, DW, DW/8, 1  master 0 request fields
- m0_cyc_i, m0_stb_i  in  1 each  master 0 cycle/strobe
- m0_dat_o  out  DW  read data (slave data when granted, else 0)
- m0_ack_o, m0_err_o  out  1 each  termination to master 0
- m1_*: identical set to m0_*, for master 1
- s_adr_o, s_dat_o, s_sel_o, s_we_o  out  AW, DW, DW/8, 1  muxed request to SDRAM controller
- s_cyc_o, s_stb_o  out  1 each  muxed cycle/strobe
- s_dat_i, s_ack_i, s_err_i  in  DW, 1, 1  slave response
- gnt_o  out  2  one-hot current grant (00 = idle)

## Operation
- FSM states: IDLE, OWN0, OWN1. Grant and last-owner pointer are registered.
- IDLE: if exactly one mi_cyc_i is high, go to OWNi. If both are high, go to the master that is not the last owner. Stay in IDLE if neither is high.
- OWNi: stay while mi_cyc_i = 1. When mi_cyc_i = 0, return to IDLE and set last = i.
- Slave outputs follow the granted master combinationally. In IDLE, s_cyc_o, s_stb_o and s_we_o are 0; s_adr_o, s_dat_o and s_sel_o are 0.
- s_ack_i, s_err_i and s_dat_i are routed only to the granted master. The non-granted master sees ack = err = 0 and dat = 0.
- A master's stb without cyc is ignored. A master never owns the bus without cyc.

## Timing
- Reset (wb_rst_n low, async): state IDLE, last = 1 (m0 wins the first tie), gnt_o = 00. All s_* outputs and all m*_ack_o/err_o are 0.
- Grant latency: 1 cycle. A request seen in IDLE at edge k drives s_cyc_o from cycle k+1.
- Ownership change: at least one cycle with s_cyc_o = 0 between owners.
- Throughput: back-to-back strobes within one owner's cycle pass with zero added latency. ack is combinational pass-through.
- Simultaneous owner release and other master's request: release → IDLE (1 cycle) → grant the other master.
- Reset mid-cycle: outputs drop to 0 immediately and the grant is lost. Masters must restart.

## Configuration
- SDRAM_WB_ARB_WDOG_EN defined:
  - An 8-bit counter runs while granted with s_stb_o = 1 and no s_ack_i/s_err_i. It clears on ack, err, or change of state.
  - When the count reaches TIMEOUT, the owner gets a 1-cycle mi_err_o. s_cyc_o and s_stb_o are forced to 0 from that cycle until the owner drops cyc, then the FSM returns to IDLE normally.
  - An s_ack_i arriving in the abort window is discarded.
- Not defined: no counter, no forced err. A hung slave holds the grant indefinitely. Logic must be removed entirely, not just tied off.

## Test plan
- Single master: m0 writes 0xDEADBEEF to 0x100 with ack after 3 cycles → s_cyc_o rises 1 cycle after m0_cyc_i; m0_ack_o is high 1 cycle; gnt_o = 01; m1 sees no ack.
- Tie after reset: m0 and m1 assert cyc in the same cycle → m0 granted first; after m0 drops cyc, 1 idle cycle, then m1 granted (gnt_o 01 → 00 → 10).
- Round-robin fairness: both masters request continuously for 10 single-beat cycles → grants alternate 0,1,0,1…; neither master gets two grants in a row.
- Hold: m1 owns the bus and issues 4 back-to-back stb/ack beats while m0 requests → all 4 beats complete without interruption, then m0 is granted.
- Watchdog (with SDRAM_WB_ARB_WDOG_EN, TIMEOUT = 16): slave never acks → m0_err_o pulses at the 16th stalled cycle and s_cyc_o = 0 afterwards. Without the macro, the bus stays granted for 1000 cycles with no err.
- Async reset asserted mid-transfer → s_cyc_o, gnt_o and acks go to 0 without waiting for a clock edge. After release, m0 wins the first tie.

Source files
------------

// File: rtl/sdram_wb_arbiter.sv
// Two-master to one-slave Wishbone classic arbiter in front of the SDRAM controller.
// Optional watchdog abort is enabled by defining SDRAM_WB_ARB_WDOG_EN.
module sdram_wb_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk,
  input  logic            wb_rst_n,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      gnt_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_last;
  logic       w_last_next;
  logic [1:0] r_gnt;
  logic       w_ack;
  logic       w_err;

  assign gnt_o = r_gnt;

  // State, last-owner pointer and grant register
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_gnt   <= 2'b00;
    end else begin
      r_state <= w_next;
      r_last  <= w_last_next;
      r_gnt   <= {w_next == OWN1, w_next == OWN0};
    end
  end

  // Next-state: ties go to whichever master did not own the bus last
  always_comb begin
    w_next      = r_state;
    w_last_next = r_last;
    case (r_state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          w_next = r_last ? OWN0 : OWN1;
        end else if (m0_cyc_i) begin
          w_next = OWN0;
        end else if (m1_cyc_i) begin
          w_next = OWN1;
        end else begin
          w_next = IDLE;
        end
      end
      OWN0: begin
        if (!m0_cyc_i) begin
          w_next      = IDLE;
          w_last_next = 1'b0;
        end else begin
          w_next = OWN0;
        end
      end
      OWN1: begin
        if (!m1_cyc_i) begin
          w_next      = IDLE;
          w_last_next = 1'b1;
        end else begin
          w_next = OWN1;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

`ifdef SDRAM_WB_ARB_WDOG_EN
  logic [7:0] r_wdog;
  logic       r_abort;
  logic       w_req_stb;
  logic       w_stall;
  logic       w_hit;
  logic       w_kill;

  // Stall detection uses the owner's raw strobe so the abort gating cannot feed back into it
  assign w_req_stb = (r_state == OWN0) ? (m0_cyc_i & m0_stb_i) :
                     (r_state == OWN1) ? (m1_cyc_i & m1_stb_i) : 1'b0;
  assign w_stall   = w_req_stb & ~r_abort & ~s_ack_i & ~s_err_i;
  assign w_hit     = w_stall & (r_wdog == 8'(TIMEOUT - 1));
  assign w_kill    = r_abort | w_hit;

  // Watchdog counter and abort window, both cleared when ownership moves
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_wdog  <= 8'd0;
      r_abort <= 1'b0;
    end else if (w_next != r_state) begin
      r_wdog  <= 8'd0;
      r_abort <= 1'b0;
    end else begin
      if (s_ack_i || s_err_i) begin
        r_wdog <= 8'd0;
      end else if (w_stall) begin
        r_wdog <= r_wdog + 8'd1;
      end else begin
        r_wdog <= r_wdog;
      end
      r_abort <= r_abort | w_hit;
    end
  end
`endif

  // Request mux toward the slave and response routing back to the owner
  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
`ifdef SDRAM_WB_ARB_WDOG_EN
    w_ack = s_ack_i & ~w_kill;
    w_err = w_kill ? w_hit : s_err_i;
`else
    w_ack = s_ack_i;
    w_err = s_err_i;
`endif
    case (r_state)
      OWN0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = m0_we_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_cyc_i & m0_stb_i;
        m0_dat_o = s_dat_i;
        m0_ack_o = w_ack;
        m0_err_o = w_err;
      end
      OWN1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_cyc_i & m1_stb_i;
        m1_dat_o = s_dat_i;
        m1_ack_o = w_ack;
        m1_err_o = w_err;
      end
      default: begin
      end
    endcase
`ifdef SDRAM_WB_ARB_WDOG_EN
    if (w_kill) begin
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
    end else begin
      s_cyc_o = s_cyc_o;
      s_stb_o = s_stb_o;
    end
`endif
  end

endmodule
